ysyx_22040759_csr_file: RTL and testbench
=========================================

# ysyx_22040759_csr_file

Machine-mode CSR register file and trap sequencer; sits directly downstream of the CSR logic unit in the execute/commit path. It serves the unit's combinational CSR read, and commits its CSR write. It takes the exception vector for the committing instruction and updates mepc/mcause/mstatus, then drives a registered PC redirect to fetch with a valid/ready handshake.

## Interface
- No parameters.
- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `commit_valid` in 1: instruction in the CSR stage commits this cycle.
- `commit_pc` in 64: PC of the committing instruction.
- `exception_tpye` in 17: bit0 ecall, bit1 ebreak, bit2 mret, bit3 illegal instruction, bit4 clint, bit5 fence.i, others reserved/ignored.
- `csr_raddr` in 12: read address.
- `csr_rdata` out 64: read data, combinational.
- `csr_wen`, `csr_waddr`[12], `csr_wdata`[64] in: write port.
- `mtip` in 1: machine timer pending from CLINT.
- `commit_kill` out 1: combinational; committing instruction is suppressed by an interrupt.
- `busy` out 1: high in REDIRECT; upstream must hold `commit_valid` low.
- `redirect_valid` out 1, `redirect_pc` out 64, `redirect_ready` in 1: redirect handshake to fetch.

## Operation
- Implemented CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00, minstret 0xB02, mhartid 0xF14.
- Other addresses read 0; writes are ignored.
- mstatus: only MIE[3], MPIE[7] are writable. MPP[12:11] always reads 2'b11. Other bits read 0.
- mie: only MTIE[7] is writable.
- mip: MTIP[7] = `mtip` and is read-only.
- mtvec: direct mode only; bits[1:0] are forced to 0 on write.
- mepc: bits[1:0] are forced to 0.
- mhartid reads 0.
- Trap event, evaluated only when `commit_valid` and state is IDLE. Priority order:
  - timer interrupt: mstatus.MIE & mie.MTIE & `mtip`; asserts `commit_kill`.
  - illegal (bit3).
  - ecall (bit0).
  - ebreak (bit1).
  - mret (bit2).
- mcause values: interrupt 0x8000_0000_0000_0007; illegal 2; ebreak 3; ecall 11.
- Trap entry: mepc←`commit_pc`; mcause set; MPIE←MIE; MIE←0. Redirect target is mtvec.
- mret: MIE←MPIE; MPIE←1. Redirect target is mepc.
- A trap or mret in the same cycle as `csr_wen` drops the CSR write.
- fence.i (bit5) and clint (bit4) are ignored here.
- FSM IDLE→REDIRECT on a trap or mret. REDIRECT→IDLE when `redirect_valid & redirect_ready`.
- minstret increments on `commit_valid` with no trap or mret taken.
- mcycle increments every cycle.
- A software write to a counter wins over its increment in that cycle.
- Counters wrap at 2^64 without a flag.

## Timing
- Reset values:
  - mstatus = 0x1800; all other CSRs = 0.
  - state IDLE; `redirect_valid` = 0; `redirect_pc` = 0; `busy` = 0.
- Reset asserted mid-REDIRECT aborts the redirect immediately.
- `csr_rdata` reflects current register state in the same cycle.
- A write becomes visible the cycle after `csr_wen`. Read of the same address in the write cycle returns the old value.
- Trap at edge N: CSRs update at N. `redirect_valid`/`redirect_pc` are registered and high from N+1.
- `redirect_pc` is held stable until accepted. Valid/ready acceptance in cycle M gives IDLE and `redirect_valid` = 0 at M+1.
- Minimum trap-to-next-commit turnaround is 2 cycles.
- mret reads mepc/MPIE before any same-cycle update, because the write is dropped.

## Configuration
- `YSYX_22040759_CSR_COUNTER_EN` defined: mcycle/minstret are implemented as above.
- Undefined: 0xB00/0xB02 read 0, writes are ignored, and no counter flops exist.

## Structure
- Shared define file holds:
  - CSR address constants;
  - mcause codes;
  - `exception_tpye` bit indices;
  - FSM state encodings.
- One sub-module, `ysyx_22040759_csr_counter`: 64-bit counter with increment enable, write enable and write data. It is instantiated twice under the macro.

## Test plan
- Reset, then read mstatus → 0x1800. mtvec, mepc, mcause → 0. `redirect_valid` = 0.
- Write mtvec = 0x8000_0103, then ecall at PC 0x8000_0040:
  - mepc = 0x8000_0040, mcause = 11, mtvec reads 0x8000_0100.
  - `redirect_pc` = 0x8000_0100 the next cycle.
  - Hold `redirect_ready` = 0 for 3 cycles: valid and PC stay stable.
- mret after ecall:
  - With MPIE = 1: MIE = 1, redirect to mepc.
  - Simultaneous `csr_wen` to mscratch: value unchanged.
- MIE = 1, MTIE = 1, `mtip` = 1 with committing illegal at PC 0x100:
  - `commit_kill` = 1, mcause = 0x8000_0000_0000_0007, MIE = 0.
- Counters (macro on):
  - Write mcycle = 0xFFFF_FFFF_FFFF_FFFF; it reads 0 one cycle after the write takes effect.
  - 5 non-trapping commits → minstret +5.
  - Macro off → both read 0.
- Assert `reset` during REDIRECT → `redirect_valid` drops without a clock edge; state IDLE.

Source files
------------

// File: rtl/ysyx_22040759_csr_file_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses, mcause codes,
// exception_tpye bit positions and trap sequencer state encodings.
package ysyx_22040759_csr_file_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam logic [63:0] MCAUSE_IRQ_TIMER = 64'h8000_0000_0000_0007;
  localparam logic [63:0] MCAUSE_ILLEGAL   = 64'd2;
  localparam logic [63:0] MCAUSE_EBREAK    = 64'd3;
  localparam logic [63:0] MCAUSE_ECALL     = 64'd11;

  localparam int EXC_ECALL   = 0;
  localparam int EXC_EBREAK  = 1;
  localparam int EXC_MRET    = 2;
  localparam int EXC_ILLEGAL = 3;
  localparam int EXC_CLINT   = 4;
  localparam int EXC_FENCEI  = 5;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } csr_state_e;

  // MPP is hard-wired to machine mode; only MIE and MPIE carry state.
  function automatic logic [63:0] mstatus_read(input logic mie, input logic mpie);
    logic [63:0] v;
    v        = 64'h0;
    v[12:11] = 2'b11;
    v[7]     = mpie;
    v[3]     = mie;
    return v;
  endfunction

endpackage

// File: rtl/ysyx_22040759_csr_counter.sv
// 64-bit CSR counter: a software write takes priority over the increment; wraps silently.
module ysyx_22040759_csr_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc_en,
  input  logic        wen,
  input  logic [63:0] wdata,
  output logic [63:0] value
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= 64'h0;
    end else if (wen) begin
      value <= wdata;
    end else if (inc_en) begin
      value <= value + 64'd1;
    end
  end

endmodule

// File: rtl/ysyx_22040759_csr_file.sv
// Machine-mode CSR file and trap sequencer with a registered PC redirect to fetch.
// Build option YSYX_22040759_CSR_COUNTER_EN adds the mcycle/minstret counters.
module ysyx_22040759_csr_file
  import ysyx_22040759_csr_file_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        commit_valid,
  input  logic [63:0] commit_pc,
  input  logic [16:0] exception_tpye,
  input  logic [11:0] csr_raddr,
  output logic [63:0] csr_rdata,
  input  logic        csr_wen,
  input  logic [11:0] csr_waddr,
  input  logic [63:0] csr_wdata,
  input  logic        mtip,
  output logic        commit_kill,
  output logic        busy,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  input  logic        redirect_ready
);

  csr_state_e  state;
  csr_state_e  state_next;

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        mie_mtie;
  logic [63:0] mtvec;
  logic [63:0] mscratch;
  logic [63:0] mepc;
  logic [63:0] mcause;

  logic        irq_pending;
  logic        take_irq;
  logic        take_trap;
  logic        take_mret;
  logic        take_event;
  logic [63:0] trap_cause;

  // clint and fence.i are handled elsewhere in the pipeline.
  logic        unused_exc;
  assign unused_exc = ^exception_tpye[16:4];

  assign irq_pending = mstatus_mie & mie_mtie & mtip;

  // Trap priority: timer interrupt, illegal, ecall, ebreak, then mret.
  always_comb begin
    take_irq   = 1'b0;
    take_trap  = 1'b0;
    take_mret  = 1'b0;
    trap_cause = 64'h0;
    if (commit_valid && state == ST_IDLE) begin
      if (irq_pending) begin
        take_irq   = 1'b1;
        take_trap  = 1'b1;
        trap_cause = MCAUSE_IRQ_TIMER;
      end else if (exception_tpye[EXC_ILLEGAL]) begin
        take_trap  = 1'b1;
        trap_cause = MCAUSE_ILLEGAL;
      end else if (exception_tpye[EXC_ECALL]) begin
        take_trap  = 1'b1;
        trap_cause = MCAUSE_ECALL;
      end else if (exception_tpye[EXC_EBREAK]) begin
        take_trap  = 1'b1;
        trap_cause = MCAUSE_EBREAK;
      end else if (exception_tpye[EXC_MRET]) begin
        take_mret  = 1'b1;
      end
    end
  end

  assign take_event  = take_trap | take_mret;
  assign commit_kill = take_irq;
  assign busy        = (state == ST_REDIRECT);

  // Trap/mret updates win over, and drop, any same-cycle software CSR write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mtvec        <= 64'h0;
      mscratch     <= 64'h0;
      mepc         <= 64'h0;
      mcause       <= 64'h0;
    end else if (take_trap) begin
      mepc         <= commit_pc & ~64'h3;
      mcause       <= trap_cause;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (take_mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (csr_wen) begin
      case (csr_waddr)
        CSR_MSTATUS: begin
          mstatus_mie  <= csr_wdata[3];
          mstatus_mpie <= csr_wdata[7];
        end
        CSR_MIE:      mie_mtie <= csr_wdata[7];
        CSR_MTVEC:    mtvec    <= csr_wdata & ~64'h3;
        CSR_MSCRATCH: mscratch <= csr_wdata;
        CSR_MEPC:     mepc     <= csr_wdata & ~64'h3;
        CSR_MCAUSE:   mcause   <= csr_wdata;
        default: ;
      endcase
    end
  end

`ifdef YSYX_22040759_CSR_COUNTER_EN
  logic [63:0] mcycle;
  logic [63:0] minstret;
  logic        wen_eff;

  assign wen_eff = csr_wen & ~take_event;

  ysyx_22040759_csr_counter u_mcycle (
    .clock  (clock),
    .reset  (reset),
    .inc_en (1'b1),
    .wen    (wen_eff && csr_waddr == CSR_MCYCLE),
    .wdata  (csr_wdata),
    .value  (mcycle)
  );

  ysyx_22040759_csr_counter u_minstret (
    .clock  (clock),
    .reset  (reset),
    .inc_en (commit_valid & ~take_event),
    .wen    (wen_eff && csr_waddr == CSR_MINSTRET),
    .wdata  (csr_wdata),
    .value  (minstret)
  );
`endif

  always_comb begin
    csr_rdata = 64'h0;
    case (csr_raddr)
      CSR_MSTATUS:  csr_rdata = mstatus_read(mstatus_mie, mstatus_mpie);
      CSR_MIE:      csr_rdata = {56'h0, mie_mtie, 7'h0};
      CSR_MTVEC:    csr_rdata = mtvec;
      CSR_MSCRATCH: csr_rdata = mscratch;
      CSR_MEPC:     csr_rdata = mepc;
      CSR_MCAUSE:   csr_rdata = mcause;
      CSR_MIP:      csr_rdata = {56'h0, mtip, 7'h0};
`ifdef YSYX_22040759_CSR_COUNTER_EN
      CSR_MCYCLE:   csr_rdata = mcycle;
      CSR_MINSTRET: csr_rdata = minstret;
`endif
      default:      csr_rdata = 64'h0;
    endcase
  end

  // Redirect handshake: redirect_valid rises the cycle after a trap/mret and,
  // with redirect_pc, holds until a cycle where redirect_valid & redirect_ready.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (take_event) state_next = ST_REDIRECT;
      ST_REDIRECT: if (redirect_valid && redirect_ready) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= 64'h0;
    end else begin
      state          <= state_next;
      redirect_valid <= (state_next == ST_REDIRECT);
      if (take_trap) begin
        redirect_pc <= mtvec;
      end else if (take_mret) begin
        redirect_pc <= mepc;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040759_csr_file.sv
// Directed bench for ysyx_22040759_csr_file: CSR write/read vector table plus
// hand-written trap, mret, interrupt, counter and reset-abort sequences.
module tb_ysyx_22040759_csr_file;

`ifdef YSYX_22040759_CSR_COUNTER_EN
  localparam bit COUNTERS = 1'b1;
`else
  localparam bit COUNTERS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        commit_valid = 1'b0;
  logic [63:0] commit_pc = 64'h0;
  logic [16:0] exception_tpye = 17'h0;
  logic [11:0] csr_raddr = 12'h0;
  logic [63:0] csr_rdata;
  logic        csr_wen = 1'b0;
  logic [11:0] csr_waddr = 12'h0;
  logic [63:0] csr_wdata = 64'h0;
  logic        mtip = 1'b0;
  logic        commit_kill;
  logic        busy;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        redirect_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #50 clock = ~clock;

  ysyx_22040759_csr_file dut (
    .clock          (clock),
    .reset          (reset),
    .commit_valid   (commit_valid),
    .commit_pc      (commit_pc),
    .exception_tpye (exception_tpye),
    .csr_raddr      (csr_raddr),
    .csr_rdata      (csr_rdata),
    .csr_wen        (csr_wen),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .mtip           (mtip),
    .commit_kill    (commit_kill),
    .busy           (busy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready)
  );

  typedef struct {
    logic [11:0] waddr;
    logic [63:0] wdata;
    logic        mtip;
    logic [63:0] exp;
  } wvec_t;

  wvec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_csr(input string name, input logic [11:0] a, input logic [63:0] exp);
    csr_raddr = a;
    #1;
    check(name, csr_rdata, exp);
  endtask

  task automatic write_csr(input logic [11:0] a, input logic [63:0] d);
    csr_wen   = 1'b1;
    csr_waddr = a;
    csr_wdata = d;
    tick();
    csr_wen   = 1'b0;
  endtask

  task automatic commit(input logic [63:0] pc, input logic [16:0] ex);
    commit_valid   = 1'b1;
    commit_pc      = pc;
    exception_tpye = ex;
  endtask

  task automatic end_commit();
    commit_valid   = 1'b0;
    exception_tpye = 17'h0;
  endtask

  task automatic accept_redirect();
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h1888};
    vecs[1]  = '{12'h300, 64'h0,                   1'b0, 64'h1800};
    vecs[2]  = '{12'h304, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h80};
    vecs[3]  = '{12'h304, 64'h0,                   1'b0, 64'h0};
    vecs[4]  = '{12'h305, 64'h8000_0103,           1'b0, 64'h8000_0100};
    vecs[5]  = '{12'h341, 64'h1237,                1'b0, 64'h1234};
    vecs[6]  = '{12'h340, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[7]  = '{12'h342, 64'h5,                   1'b0, 64'h5};
    vecs[8]  = '{12'hF14, 64'h55,                  1'b0, 64'h0};
    vecs[9]  = '{12'h7C0, 64'h99,                  1'b0, 64'h0};
    vecs[10] = '{12'h344, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0};
    vecs[11] = '{12'h344, 64'h0,                   1'b1, 64'h80};

    // Reset
    tick();
    tick();
    reset = 1'b0;
    check_csr("reset_mstatus", 12'h300, 64'h1800);
    check_csr("reset_mtvec",   12'h305, 64'h0);
    check_csr("reset_mepc",    12'h341, 64'h0);
    check_csr("reset_mcause",  12'h342, 64'h0);
    check("reset_redirect_valid", {63'h0, redirect_valid}, 64'h0);
    check("reset_redirect_pc", redirect_pc, 64'h0);
    check("reset_busy", {63'h0, busy}, 64'h0);

    // Write/read vector table
    for (int i = 0; i < 12; i++) begin
      csr_wen   = 1'b1;
      csr_waddr = vecs[i].waddr;
      csr_wdata = vecs[i].wdata;
      csr_raddr = vecs[i].waddr;
      mtip      = vecs[i].mtip;
      tick();
      csr_wen   = 1'b0;
      #1;
      check($sformatf("vec%0d_addr_%03h", i, vecs[i].waddr), csr_rdata, vecs[i].exp);
    end
    mtip = 1'b0;

    // Same-cycle read returns the old value
    csr_wen   = 1'b1;
    csr_waddr = 12'h340;
    csr_wdata = 64'h0123_4567_89AB_CDEF;
    check_csr("write_cycle_old_value", 12'h340, 64'hDEAD_BEEF_CAFE_F00D);
    tick();
    csr_wen = 1'b0;
    check_csr("write_next_cycle_new", 12'h340, 64'h0123_4567_89AB_CDEF);

    // ecall with MIE=1, mtvec=0x8000_0100
    write_csr(12'h300, 64'h8);
    commit(64'h8000_0040, 17'h1);
    #1;
    check("ecall_no_kill", {63'h0, commit_kill}, 64'h0);
    tick();
    end_commit();
    check_csr("ecall_mepc",    12'h341, 64'h8000_0040);
    check_csr("ecall_mcause",  12'h342, 64'd11);
    check_csr("ecall_mtvec",   12'h305, 64'h8000_0100);
    check_csr("ecall_mstatus", 12'h300, 64'h1880);
    check("ecall_redirect_valid", {63'h0, redirect_valid}, 64'h1);
    check("ecall_redirect_pc", redirect_pc, 64'h8000_0100);
    check("ecall_busy", {63'h0, busy}, 64'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold%0d_valid", i), {63'h0, redirect_valid}, 64'h1);
      check($sformatf("hold%0d_pc", i), redirect_pc, 64'h8000_0100);
    end
    accept_redirect();
    check("accept_valid_low", {63'h0, redirect_valid}, 64'h0);
    check("accept_busy_low", {63'h0, busy}, 64'h0);

    // mret with a simultaneous mscratch write that must be dropped
    commit(64'h8000_0044, 17'h4);
    csr_wen   = 1'b1;
    csr_waddr = 12'h340;
    csr_wdata = 64'hFFFF;
    tick();
    end_commit();
    csr_wen = 1'b0;
    check_csr("mret_mscratch_kept", 12'h340, 64'h0123_4567_89AB_CDEF);
    check_csr("mret_mstatus", 12'h300, 64'h1888);
    check("mret_redirect_valid", {63'h0, redirect_valid}, 64'h1);
    check("mret_redirect_pc", redirect_pc, 64'h8000_0040);
    accept_redirect();
    check("mret_accept_valid_low", {63'h0, redirect_valid}, 64'h0);

    // Timer interrupt pre-empts a committing illegal instruction
    write_csr(12'h304, 64'h80);
    mtip = 1'b1;
    commit(64'h100, 17'h8);
    #1;
    check("irq_commit_kill", {63'h0, commit_kill}, 64'h1);
    tick();
    end_commit();
    check_csr("irq_mcause",  12'h342, 64'h8000_0000_0000_0007);
    check_csr("irq_mstatus", 12'h300, 64'h1880);
    check_csr("irq_mepc",    12'h341, 64'h100);
    check_csr("irq_mip",     12'h344, 64'h80);
    check("irq_redirect_pc", redirect_pc, 64'h8000_0100);
    accept_redirect();

    // MIE now 0: illegal beats ecall, no kill despite mtip
    commit(64'h206, 17'h9);
    #1;
    check("illegal_no_kill", {63'h0, commit_kill}, 64'h0);
    tick();
    end_commit();
    check_csr("illegal_mcause", 12'h342, 64'd2);
    check_csr("illegal_mepc",   12'h341, 64'h204);
    accept_redirect();

    // ebreak beats mret
    commit(64'h300, 17'h6);
    tick();
    end_commit();
    check_csr("ebreak_mcause",  12'h342, 64'd3);
    check_csr("ebreak_mstatus", 12'h300, 64'h1800);
    check("ebreak_redirect_pc", redirect_pc, 64'h8000_0100);
    accept_redirect();
    mtip = 1'b0;

    // Counters
    write_csr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    check_csr("mcycle_written", 12'hB00, COUNTERS ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0);
    tick();
    check_csr("mcycle_wrapped", 12'hB00, 64'h0);
    write_csr(12'hB02, 64'h0);
    for (int i = 0; i < 5; i++) begin
      commit(64'h400 + 64'(i * 4), 17'h0);
      tick();
    end
    end_commit();
    tick();
    check_csr("minstret_plus5", 12'hB02, COUNTERS ? 64'd5 : 64'd0);

    // Reset asserted mid-redirect aborts at once
    commit(64'h500, 17'h1);
    tick();
    end_commit();
    check("abort_pre_valid", {63'h0, redirect_valid}, 64'h1);
    reset = 1'b1;
    #1;
    check("abort_valid_low", {63'h0, redirect_valid}, 64'h0);
    check("abort_busy_low", {63'h0, busy}, 64'h0);
    check("abort_pc_zero", redirect_pc, 64'h0);
    tick();
    reset = 1'b0;
    check_csr("abort_mstatus", 12'h300, 64'h1800);
    check_csr("abort_mtvec",   12'h305, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
